// File: rtl/ika2151_so_dec.sv
// YM3012-style DAC input stage: deserialises the 13-bit floating-point SO words
// framed by SH1 (right) / SH2 (left) and decodes them to signed 16-bit PCM.
module ika2151_so_dec #(
  parameter bit HOLD_ON_ERR = 1'b1
) (
  input  logic        i_EMUCLK,
  input  logic        i_MRST,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  output logic [15:0] o_PCM_R,
  output logic [15:0] o_PCM_L,
  output logic        o_VALID_R,
  output logic        o_VALID_L,
  output logic        o_FRAME_ERR
);

  logic        en;
  logic        sh1_z, sh2_z;
  logic        act1, act2;
  logic        rise1, rise2, fall1, fall2;
  logic        start, close_r, close_l, short_word;
  logic        own_l;
  logic [12:0] word;
  logic [4:0]  cnt;

  logic [12:0] s1_word;
  logic        s1_r_vld, s1_l_vld, s1_r_upd, s1_l_upd;

  logic [9:0]  m10;
  logic [2:0]  expo;
  logic [15:0] pcm;

  assign en    = ~i_phi1_NCEN_n;
  assign act1  = i_SH1;
  assign act2  = i_SH2 & ~i_SH1;
  assign rise1 = i_SH1 & ~sh1_z;
  assign rise2 = i_SH2 & ~sh2_z;
  assign fall1 = ~i_SH1 & sh1_z;
  assign fall2 = ~i_SH2 & sh2_z;
  assign start = (act1 & rise1) | (act2 & rise2);

  // A falling edge closes the word only for the channel that opened it, so an
  // SH2 pulse swallowed by an SH1 overlap cannot steal the right-channel word.
  assign close_r    = fall1 & ~own_l;
  assign close_l    = fall2 & own_l;
  assign short_word = (cnt < 5'd13);

  // Edge history, capture shift register and owner of the word in flight
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      sh1_z <= 1'b0;
      sh2_z <= 1'b0;
      own_l <= 1'b0;
      word  <= '0;
      cnt   <= '0;
    end else if (en) begin
      sh1_z <= i_SH1;
      sh2_z <= i_SH2;
      if (start) begin
        own_l   <= act2;
        word[0] <= i_SO;
        cnt     <= 5'd1;
      end else if (act1 | act2) begin
        if (short_word) word[cnt[3:0]] <= i_SO;
        if (cnt != 5'd16) cnt <= cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      o_FRAME_ERR <= 1'b0;
    end else if (en) begin
      if ((i_SH1 & i_SH2) | ((close_r | close_l) & short_word)) o_FRAME_ERR <= 1'b1;
    end
  end

  // Decode stage 1: latch the closed word and what the output stage must do
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      s1_word  <= '0;
      s1_r_vld <= 1'b0;
      s1_l_vld <= 1'b0;
      s1_r_upd <= 1'b0;
      s1_l_upd <= 1'b0;
    end else if (en) begin
      if (close_r | close_l) s1_word <= word;
      s1_r_vld <= close_r & ~short_word;
      s1_l_vld <= close_l & ~short_word;
      s1_r_upd <= close_r & (~short_word | ~HOLD_ON_ERR);
      s1_l_upd <= close_l & (~short_word | ~HOLD_ON_ERR);
    end
  end

  // Offset-binary mantissa to two's complement, then scale by the exponent
  always_comb begin
    m10  = {s1_word[9], s1_word[8:0]} ^ 10'h200;
    expo = s1_word[12:10];
    pcm  = '0;
    if (expo != 3'd0) pcm = {{6{m10[9]}}, m10} << (expo - 3'd1);
  end

  // Decode stage 2: outputs; strobes only move on enabled cycles
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      o_PCM_R   <= '0;
      o_PCM_L   <= '0;
      o_VALID_R <= 1'b0;
      o_VALID_L <= 1'b0;
    end else if (en) begin
      o_VALID_R <= s1_r_vld;
      o_VALID_L <= s1_l_vld;
      if (s1_r_upd) o_PCM_R <= pcm;
      if (s1_l_upd) o_PCM_L <= pcm;
    end
  end

endmodule

// File: tb/tb_ika2151_so_dec.sv
// Scoreboard bench for ika2151_so_dec: frames are driven bit by bit, expected
// PCM words (with their due enabled-cycle index) are queued and checked on strobes.
module tb_ika2151_so_dec;

  logic        i_EMUCLK = 1'b0;
  logic        i_MRST;
  logic        i_phi1_NCEN_n;
  logic        i_SO;
  logic        i_SH1;
  logic        i_SH2;
  logic [15:0] o_PCM_R;
  logic [15:0] o_PCM_L;
  logic        o_VALID_R;
  logic        o_VALID_L;
  logic        o_FRAME_ERR;

  ika2151_so_dec dut (
    .i_EMUCLK      (i_EMUCLK),
    .i_MRST        (i_MRST),
    .i_phi1_NCEN_n (i_phi1_NCEN_n),
    .i_SO          (i_SO),
    .i_SH1         (i_SH1),
    .i_SH2         (i_SH2),
    .o_PCM_R       (o_PCM_R),
    .o_PCM_L       (o_PCM_L),
    .o_VALID_R     (o_VALID_R),
    .o_VALID_L     (o_VALID_L),
    .o_FRAME_ERR   (o_FRAME_ERR)
  );

  // clock / reset
  always #5 i_EMUCLK = ~i_EMUCLK;

  int          total = 0;
  int          bad   = 0;
  int          ecnt  = 0;
  bit          gate  = 1'b0;
  logic [15:0] last_r;
  // {enabled-cycle index when due, pcm}
  logic [47:0] exp_r_q[$];
  logic [47:0] exp_l_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [12:0] w);
    int          d;
    int          v;
    int          e;
    logic [31:0] t;
    d = int'(w[8:0]);
    v = w[9] ? d : d - 512;
    e = int'(w[12:10]);
    if (e == 0) return 16'h0000;
    t = v * (1 << (e - 1));
    return t[15:0];
  endfunction

  // driver: optional disabled stretch, then one enabled cycle
  task automatic cyc(input bit s1, input bit s2, input bit d);
    i_SH1 = s1;
    i_SH2 = s2;
    if (gate) begin
      repeat ($urandom_range(0, 3)) begin
        i_phi1_NCEN_n = 1'b1;
        i_SO = 1'($urandom_range(0, 1));
        @(posedge i_EMUCLK); #1;
      end
    end
    i_phi1_NCEN_n = 1'b0;
    i_SO = d;
    @(posedge i_EMUCLK); #1;
    ecnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic push(input bit ch_l, input logic [12:0] w);
    logic [31:0] due;
    due = 32'(ecnt - 1 + 2);
    if (ch_l) exp_l_q.push_back({due, model(w)});
    else      exp_r_q.push_back({due, model(w)});
  endtask

  task automatic send(input bit ch_l, input logic [12:0] w, input int n);
    for (int i = 0; i < n; i++)
      cyc(!ch_l, ch_l, (i < 13) ? w[i] : 1'($urandom_range(0, 1)));
    cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    if (n >= 13) push(ch_l, w);
    idle(3);
  endtask

  task automatic send_b2b(input logic [12:0] wr, input logic [12:0] wl);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, (i < 13) ? wr[i] : 1'b0);
    cyc(1'b0, 1'b1, wl[0]);
    push(1'b0, wr);
    for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, (i < 13) ? wl[i] : 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    push(1'b1, wl);
    idle(3);
  endtask

  // scoreboard: compare on every enabled cycle that shows a strobe
  always @(negedge i_EMUCLK) begin
    logic [47:0] e;
    if (!i_MRST && !i_phi1_NCEN_n) begin
      if (o_VALID_R) begin
        if (exp_r_q.size() == 0) chk("r_spurious_strobe", 32'd1, 32'd0);
        else begin
          e = exp_r_q.pop_front();
          chk("r_pcm", 32'(o_PCM_R), 32'(e[15:0]));
          chk("r_latency", 32'(ecnt), e[47:16]);
        end
      end
      if (o_VALID_L) begin
        if (exp_l_q.size() == 0) chk("l_spurious_strobe", 32'd1, 32'd0);
        else begin
          e = exp_l_q.pop_front();
          chk("l_pcm", 32'(o_PCM_L), 32'(e[15:0]));
          chk("l_latency", 32'(ecnt), e[47:16]);
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pcm_r"}, 32'(o_PCM_R), 32'd0);
    chk({tag, "_pcm_l"}, 32'(o_PCM_L), 32'd0);
    chk({tag, "_vld_r"}, 32'(o_VALID_R), 32'd0);
    chk({tag, "_vld_l"}, 32'(o_VALID_L), 32'd0);
    chk({tag, "_err"}, 32'(o_FRAME_ERR), 32'd0);
  endtask

  task automatic do_reset();
    i_MRST = 1'b1;
    i_SH1 = 1'b0;
    i_SH2 = 1'b0;
    #2;
    chk_reset_state("reset");
    repeat (2) @(posedge i_EMUCLK);
    #1;
    i_MRST = 1'b0;
  endtask

  initial begin
    logic [12:0] wa;
    logic [12:0] wb;
    i_MRST = 1'b1;
    i_phi1_NCEN_n = 1'b0;
    i_SO = 1'b0;
    i_SH1 = 1'b0;
    i_SH2 = 1'b0;
    repeat (3) @(posedge i_EMUCLK);
    #1;
    do_reset();
    idle(2);

    // directed words
    send(1'b0, {3'd7, 1'b1, 9'h1FF}, 16);
    chk("r_full_scale", 32'(o_PCM_R), 32'h7FC0);
    chk("l_untouched", 32'(o_PCM_L), 32'h0);
    send(1'b1, {3'd1, 1'b0, 9'h000}, 16);
    chk("l_neg_min", 32'(o_PCM_L), 32'hFE00);
    send(1'b1, {3'd3, 1'b1, 9'h000}, 16);
    chk("l_zero_mid", 32'(o_PCM_L), 32'h0);
    send(1'b1, {3'd0, 1'($urandom_range(0, 1)), 9'($urandom_range(1, 511))}, 16);
    chk("l_exp0", 32'(o_PCM_L), 32'h0);
    chk("exp0_no_err", 32'(o_FRAME_ERR), 32'd0);
    send(1'b0, {3'd4, 1'b0, 9'h155}, 13);
    chk("exactly13_no_err", 32'(o_FRAME_ERR), 32'd0);

    // back-to-back frames and random words, ungated then gated
    for (int k = 0; k < 3; k++) begin
      wa = 13'($urandom_range(0, 8191));
      wb = 13'($urandom_range(0, 8191));
      send_b2b(wa, wb);
    end
    gate = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wa = 13'($urandom_range(0, 8191));
      send(k[0], wa, $urandom_range(13, 18));
    end
    send_b2b(13'h1E5A, 13'h0A3C);
    gate = 1'b0;
    chk("random_no_err", 32'(o_FRAME_ERR), 32'd0);

    // short frame: error, no strobe, output held
    last_r = o_PCM_R;
    send(1'b0, 13'h1ABC, 10);
    idle(3);
    chk("short_err", 32'(o_FRAME_ERR), 32'd1);
    chk("short_hold", 32'(o_PCM_R), 32'(last_r));
    idle(4);
    chk("r_queue_drained", 32'(exp_r_q.size()), 32'd0);
    chk("l_queue_drained", 32'(exp_l_q.size()), 32'd0);

    // overlap then reset mid-frame
    do_reset();
    send(1'b0, {3'd5, 1'b1, 9'h0F0}, 16);
    send(1'b1, {3'd6, 1'b0, 9'h10F}, 16);
    idle(2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("overlap_err", 32'(o_FRAME_ERR), 32'd1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    do_reset();
    idle(6);
    chk("abort_no_strobe_pcm_r", 32'(o_PCM_R), 32'd0);
    chk("abort_err_clear", 32'(o_FRAME_ERR), 32'd0);
    chk("final_r_queue", 32'(exp_r_q.size()), 32'd0);
    chk("final_l_queue", 32'(exp_l_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
